// File: rtl/wb_regfile.sv
// Writeback-stage register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational reads, one write, x0 hardwired to 0.
// Optional macro WB_REGFILE_BYPASS_EN forwards the writeback value to a same-cycle read of the destination index.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int A0_IDX   = 10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  always_comb begin
    // NOTE: assign a default before the case so every path drives ResultW and no latch is inferred.
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  assign wr_en = RegWriteW && (RdW != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every entry is cleared on reset because software relies on zeroed registers; this keeps the array in flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking so same-edge readers of regs see the pre-edge value.
      regs[RdW] <= ResultW;
    end
  end

  // Index 0 is forced to zero on the read side so it is 0 even before the first reset.
  always_comb begin
    RD1D = (Rs1D == '0) ? '0 : regs[Rs1D];
    RD2D = (Rs2D == '0) ? '0 : regs[Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
    if (!reset && wr_en && (RdW == Rs1D)) RD1D = ResultW;
    if (!reset && wr_en && (RdW == Rs2D)) RD2D = ResultW;
`endif
  end

  generate
    if (NUM_REGS > A0_IDX) begin : g_a0
      assign a0 = regs[A0_IDX];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic against an array-based reference model.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteW;
  logic [1:0]    ResultSrcW;
  logic [DW-1:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [AW-1:0] RdW, Rs1D, Rs2D;
  logic [DW-1:0] RD1D, RD2D, ResultW, a0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] model_mem [N];
  bit            model_valid = 1'b0;

  wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_result();
    if (ResultSrcW == 2'd0) return ALUResultW;
    if (ResultSrcW == 2'd1) return ReadDataW;
    if (ResultSrcW == 2'd2) return PCPlus4W;
    return '0;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
    if (!reset && RegWriteW && RdW != 0 && RdW == idx) return model_result();
`endif
    return model_mem[idx];
  endfunction

  task automatic drive(input bit rst, input bit we, input logic [1:0] src,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                       input logic [DW-1:0] pc, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    reset = rst; RegWriteW = we; ResultSrcW = src;
    ALUResultW = alu; ReadDataW = rdata; PCPlus4W = pc;
    RdW = rd; Rs1D = rs1; Rs2D = rs2;
  endtask

  // Settle, compare all outputs against the model for the currently driven inputs.
  task automatic settle_check();
    #1;
    check("result", ResultW, model_result());
    if (model_valid) begin
      check("rd1", RD1D, model_read(Rs1D));
      check("rd2", RD2D, model_read(Rs2D));
      check("a0", a0, model_mem[10]);
    end
  endtask

  // Apply one rising edge and advance the model with the same rules.
  task automatic tick();
    logic [DW-1:0] res;
    res = model_result();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) model_mem[i] = '0;
      model_valid = 1'b1;
    end else if (RegWriteW && RdW != 0) begin
      model_mem[RdW] = res;
    end
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] rd, input logic [DW-1:0] val);
    drive(0, 1, 2'b00, val, 32'hDEAD_0001, 32'hDEAD_0002, rd, 0, 0);
    settle_check();
    tick();
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 1; i < N; i++) begin
      drive(0, 0, 2'b00, $urandom, $urandom, $urandom, 5'($urandom), 5'(i), 5'(i));
      settle_check();
      check(tag, RD1D, 32'h0);
      tick();
    end
  endtask

  initial begin
    logic [DW-1:0] snap [N];
    for (int i = 0; i < N; i++) model_mem[i] = 'x;
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    settle_check();
    tick();
    read_all_zero("reset_zero");

    // x5 write then read back next cycle.
    write_reg(5, 32'h0000_00AA);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5, 5);
    settle_check();
    check("x5_readback", RD1D, 32'h0000_00AA);
    tick();

    // Writes to x0 are dropped.
    write_reg(0, 32'hFFFF_FFFF);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle_check();
    check("x0_rd1", RD1D, 32'h0);
    check("x0_rd2", RD2D, 32'h0);
    tick();

    // Result select paths, each written to x10 and observed on a0.
    for (int s = 1; s < 4; s++) begin
      logic [DW-1:0] want;
      want = (s == 1) ? 32'h1234 : (s == 2) ? 32'h100 : 32'h0;
      drive(0, 1, 2'(s), 32'hCAFE_F00D, 32'h1234, 32'h100, 10, 10, 3);
      settle_check();
      check("result_sel", ResultW, want);
      tick();
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      settle_check();
      check("a0_track", a0, want);
      tick();
    end

    // Same-cycle write/read of x7.
    write_reg(7, 32'h55);
    drive(0, 1, 2'b00, 32'h66, 0, 0, 7, 7, 7);
    settle_check();
`ifdef WB_REGFILE_BYPASS_EN
    check("x7_same_cycle", RD1D, 32'h66);
`else
    check("x7_same_cycle", RD1D, 32'h55);
`endif
    tick();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 7, 7);
    settle_check();
    check("x7_next_cycle", RD1D, 32'h66);
    tick();

    // Randomized traffic, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 2'($urandom),
            $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
            ($urandom_range(0, 3) == 0) ? Rs1D : 5'($urandom));
      settle_check();
      tick();
    end

    // Reset wins over a simultaneous write.
    write_reg(3, 32'h1111);
    drive(1, 1, 2'b00, 32'h99, 0, 0, 3, 3, 3);
    settle_check();
    tick();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 3, 3);
    settle_check();
    check("x3_after_reset", RD1D, 32'h0);
    tick();
    read_all_zero("reset_write_zero");

    // Preload, then RegWriteW=0 with random everything else must leave the array alone.
    for (int i = 1; i < N; i++) write_reg(5'(i), $urandom);
    for (int i = 0; i < N; i++) snap[i] = model_mem[i];
    for (int k = 0; k < 100; k++) begin
      drive(0, 0, 2'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      settle_check();
      tick();
    end
    for (int i = 1; i < N; i++) begin
      drive(0, 0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(N - i));
      settle_check();
      check("hold_rd1", RD1D, snap[i]);
      check("hold_rd2", RD2D, snap[N - i]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width (2^ADDR_WIDTH entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RegWriteW  input  1  writeback enable from the Memory/WriteBack pipeline register.
REQ-006 SHALL have port ResultSrcW  input  2  writeback result select.
REQ-007 SHALL have port ALUResultW  input  DATA_WIDTH  ALU result from writeback stage.
REQ-008 SHALL have port ReadDataW  input  DATA_WIDTH  load data from writeback stage.
REQ-009 SHALL have port PCPlus4W  input  DATA_WIDTH  link address from writeback stage.
REQ-010 SHALL have port RdW  input  ADDR_WIDTH  destination register index.
REQ-011 SHALL have port Rs1D  input  ADDR_WIDTH  decode-stage read index 1.
REQ-012 SHALL have port Rs2D  input  ADDR_WIDTH  decode-stage read index 2.
REQ-013 SHALL have port RD1D  output  DATA_WIDTH  read data for Rs1D.
REQ-014 SHALL have port RD2D  output  DATA_WIDTH  read data for Rs2D.
REQ-015 SHALL have port ResultW  output  DATA_WIDTH  selected writeback value, also fed to the execute-stage forwarding mux.
REQ-016 SHALL have port a0  output  DATA_WIDTH  continuous view of register x10.

Function
REQ-017 SHALL compute ResultW combinationally: ResultSrcW 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> 0.
REQ-018 SHALL write ResultW into entry RdW on rising clk when RegWriteW=1, RdW!=0, reset=0; write takes one cycle (visible in array next cycle).
REQ-019 SHALL ignore writes to index 0; entry 0 SHALL read 0 at all times.
REQ-020 SHALL drive RD1D/RD2D combinationally from the array at Rs1D/Rs2D (zero-latency read).
REQ-021 SHALL treat Rs1D=Rs2D as legal; both ports return identical data.
REQ-022 SHALL hold all entries unchanged when RegWriteW=0, regardless of other inputs.
REQ-023 SHALL drive a0 from the array entry 10, updated with the same one-cycle write latency as REQ-018.
REQ-024 SHALL treat RegWriteW with unknown/invalid ResultSrcW=11 as a write of 0 to RdW (no error state).

Reset
REQ-025 SHALL, on rising clk with reset=1, clear every entry to 0; RD1D, RD2D, a0 therefore read 0 the following cycle; ResultW remains combinational.
REQ-026 SHALL give reset priority over a simultaneous write (RegWriteW=1 same edge): entry ends at 0.
REQ-027 SHALL resume normal writes on the first rising edge with reset=0 after reset deasserts.

Configuration
REQ-028 SHALL support macro WB_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
REQ-029 SHALL, with WB_REGFILE_BYPASS_EN defined, return ResultW on RD1D (RD2D) when RegWriteW=1, RdW!=0, RdW=Rs1D (Rs2D), and reset=0.
REQ-030 SHALL, without WB_REGFILE_BYPASS_EN, return the old array value in that case; new value visible next cycle.

Verification
REQ-031 SHALL cover: reset, then RegWriteW=1, ResultSrcW=00, ALUResultW=0x0000_00AA, RdW=5; next cycle Rs1D=5 -> RD1D=0x0000_00AA.
REQ-032 SHALL cover: RegWriteW=1, RdW=0, ALUResultW=0xFFFF_FFFF; next cycle Rs1D=0, Rs2D=0 -> RD1D=RD2D=0.
REQ-033 SHALL cover: ResultSrcW 01/10/11 with ReadDataW=0x1234, PCPlus4W=0x100 -> ResultW=0x1234/0x100/0; RdW=10 writes -> a0 tracks each value one cycle later.
REQ-034 SHALL cover: x7=0x55 preloaded, write RdW=7 value 0x66 with Rs1D=7 same cycle -> RD1D=0x66 with WB_REGFILE_BYPASS_EN, 0x55 without; both 0x66 next cycle.
REQ-035 SHALL cover: reset=1 and RegWriteW=1, RdW=3, value 0x99 on same edge -> x3=0 after edge; all 31 writable entries read 0.
REQ-036 SHALL cover: RegWriteW=0 with random RdW/ResultW for 100 cycles -> all entries unchanged.
